// File: rtl/event_pkg.sv
// Shared types and constants for the event pulse generator.
package event_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    ACTIVE    = 2'd2,
    RELEASING = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int GLITCH_W            = 8;

  // Saturating increment: holds at all-ones instead of wrapping to zero.
  function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer that brings an asynchronous level into the clk domain.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw level through the flop chain; the oldest stage is the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/event_pulse_gen.sv
// Debounces a synchronized event level and emits one count-enable pulse per
// clean rising event; aborted debounce attempts are counted in glitch_cnt.
module event_pulse_gen
  import event_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                event_in,
  input  logic                arm,
  output logic                enable,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam logic [7:0] DEB = 8'(DEBOUNCE_CYCLES);

  logic       s;
  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       glitch_inc;
  logic       pulse_nxt;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (event_in),
    .q     (s)
  );

  // Next-state and stability-counter logic.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_nxt  = state;
    cnt_nxt    = cnt;
    glitch_inc = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nxt = ACTIVE;
          end else begin
            state_nxt = ARMING;
            cnt_nxt   = 8'd1;
          end
        end
      end
      ARMING: begin
        if (!s) begin
          state_nxt  = IDLE;
          glitch_inc = 1'b1;
        end else if (cnt == DEB) begin
          state_nxt = ACTIVE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      ACTIVE: begin
        if (!s) begin
          state_nxt = RELEASING;
          cnt_nxt   = 8'd1;
        end
      end
      RELEASING: begin
        if (s) begin
          // Release aborted: back to ACTIVE silently, the bounce is counted.
          state_nxt  = ACTIVE;
          glitch_inc = 1'b1;
        end else if (cnt == DEB) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A pulse only accompanies a fresh entry into ACTIVE, never a return from RELEASING.
  assign pulse_nxt = arm && (state == IDLE || state == ARMING) && (state_nxt == ACTIVE);

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      enable     <= 1'b0;
      busy       <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      enable <= pulse_nxt;
      busy   <= (state_nxt != IDLE);
      if (glitch_inc) glitch_cnt <= sat_inc(glitch_cnt);
    end
  end

endmodule

// File: tb/tb_event_pulse_gen.sv
// Directed self-checking bench for event_pulse_gen at default parameters.
module tb_event_pulse_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       event_in;
  logic       arm;
  logic       enable;
  logic       busy;
  logic [7:0] glitch_cnt;

  int errors = 0;
  int checks = 0;

  event_pulse_gen dut (
    .clk        (clk),
    .reset      (reset),
    .event_in   (event_in),
    .arm        (arm),
    .enable     (enable),
    .busy       (busy),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int pulses;

  initial begin
    reset    = 1'b1;
    event_in = 1'b0;
    arm      = 1'b1;
    #1;
    check("reset_enable", enable, 0);
    check("reset_busy", busy, 0);
    check("reset_glitch", glitch_cnt, 0);
    ticks(3);
    reset = 1'b0;
    ticks(3);
    check("idle_busy", busy, 0);

    // Clean event: enable on edge 7 (first sampling edge is edge 1), busy from edge 3.
    event_in = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("clean_en_%0d", k), enable, (k == 7) ? 1 : 0);
      check($sformatf("clean_busy_%0d", k), busy, (k >= 3) ? 1 : 0);
      pulses += int'(enable);
    end
    check("clean_pulses", pulses, 1);
    event_in = 1'b0;
    ticks(12);
    check("clean_idle_busy", busy, 0);
    check("clean_glitch", glitch_cnt, 0);

    // Short high of 3 cycles: aborted during ARMING.
    event_in = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 4) event_in = 1'b0;
      tick();
      pulses += int'(enable);
    end
    check("short_pulses", pulses, 0);
    check("short_glitch", glitch_cnt, 1);
    check("short_busy", busy, 0);

    // Debounced high, 2-cycle dip, high again: no second pulse, stays ACTIVE.
    event_in = 1'b1;
    pulses = 0;
    ticks(10);
    check("dip_first_pulse_done", busy, 1);
    event_in = 1'b0;
    ticks(2);
    event_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      pulses += int'(enable);
      check($sformatf("dip_busy_%0d", k), busy, 1);
    end
    check("dip_pulses", pulses, 0);
    check("dip_glitch", glitch_cnt, 2);
    event_in = 1'b0;
    ticks(12);
    check("dip_idle_busy", busy, 0);

    // arm=0: same busy profile as the clean run, no enable, glitch_cnt untouched.
    arm = 1'b0;
    event_in = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("noarm_busy_%0d", k), busy, (k >= 3) ? 1 : 0);
      pulses += int'(enable);
    end
    check("noarm_pulses", pulses, 0);
    event_in = 1'b0;
    ticks(12);
    arm = 1'b1;
    check("noarm_idle_busy", busy, 0);
    check("noarm_glitch", glitch_cnt, 2);

    // Single-cycle glitches: each aborts ARMING once; counter saturates at 255.
    pulses = 0;
    for (int g = 1; g <= 300; g++) begin
      event_in = 1'b1;
      tick();
      event_in = 1'b0;
      for (int j = 0; j < 3; j++) begin
        tick();
        pulses += int'(enable);
      end
      if (g == 200) check("sat_mid", glitch_cnt, 202);
      if (g == 253) check("sat_reach", glitch_cnt, 255);
    end
    ticks(4);
    check("sat_hold", glitch_cnt, 255);
    check("sat_pulses", pulses, 0);
    check("sat_busy", busy, 0);

    // Reset two cycles into ARMING with event_in held high.
    event_in = 1'b1;
    ticks(4);
    check("pre_reset_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_enable", enable, 0);
    check("async_busy", busy, 0);
    check("async_glitch", glitch_cnt, 0);
    pulses = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      pulses += int'(enable);
    end
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("post_reset_en_%0d", k), enable, (k == 7) ? 1 : 0);
      pulses += int'(enable);
    end
    check("post_reset_pulses", pulses, 1);
    check("post_reset_glitch", glitch_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/event_pulse_gen.md
EVENT_PULSE_GEN -- requirements
Module: event_pulse_gen

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the number of synchronizer flops on event_in (legal 2..4).
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, sets the consecutive stable samples required (legal 1..255).
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  is the reset; it SHALL be asynchronous and active-high.
REQ-005 Port event_in  input  1  is the raw asynchronous event level from a switch or sensor.
REQ-006 Port arm  input  1  permits pulse generation when high.
REQ-007 Port enable  output  1  is a one-cycle count-enable pulse for the downstream 8-bit up counter.
REQ-008 Port busy  output  1  is high whenever the FSM is not in IDLE.
REQ-009 Port glitch_cnt  output  8  counts aborted debounce attempts, saturating.

Function
REQ-010 event_in SHALL pass through SYNC_STAGES flops; the last stage is the sampled level s.
REQ-011 FSM states SHALL be IDLE, ARMING, ACTIVE and RELEASING, with an 8-bit stability counter cnt.
REQ-012 IDLE: s=1 -> ARMING with cnt=1; otherwise stay.
REQ-013 ARMING: s=0 -> IDLE with glitch_cnt+1; s=1 with cnt=DEBOUNCE_CYCLES -> ACTIVE; else cnt+1.
REQ-014 When DEBOUNCE_CYCLES=1, IDLE with s=1 SHALL go directly to ACTIVE.
REQ-015 ACTIVE: s=0 -> RELEASING with cnt=1; otherwise stay; no further pulses.
REQ-016 RELEASING: s=1 -> ACTIVE without a new pulse and with glitch_cnt+1; s=0 with cnt=DEBOUNCE_CYCLES -> IDLE; else cnt+1.
REQ-017 enable SHALL be registered and high for exactly the first cycle the state is ACTIVE after entry from ARMING or IDLE, and only if arm=1 in the transition cycle.
REQ-018 Latency: with event_in held high, enable SHALL assert SYNC_STAGES+DEBOUNCE_CYCLES cycles after the first clk edge sampling event_in=1 (6 cycles at defaults).
REQ-019 Each debounced rising event SHALL produce at most one enable pulse; a held level SHALL never re-trigger.
REQ-020 glitch_cnt SHALL saturate at 255 and not wrap.
REQ-021 busy SHALL be registered, derived from the next-state value so that it matches the state register.
REQ-022 arm=0 SHALL suppress enable only; FSM and glitch_cnt SHALL behave identically.

Reset
REQ-023 On reset assertion, sync flops, state=IDLE, cnt, enable, busy and glitch_cnt SHALL clear to 0 immediately, independent of clk.
REQ-024 Reset mid-ARMING or mid-ACTIVE SHALL discard progress; no enable pulse SHALL issue during or on release of reset.
REQ-025 After reset deassertion, a high event_in SHALL be treated as a new event with full latency per REQ-018.

Structure
REQ-026 Package event_pkg SHALL hold the FSM state enum, the default SYNC_STAGES and DEBOUNCE_CYCLES constants, and the glitch_cnt width constant (8).
REQ-027 The synchronizer SHALL be sub-module sync_chain (parameter STAGES, async active-high reset); the FSM, counters and outputs stay in event_pulse_gen.

Verification
REQ-028 Defaults, arm=1, event_in 0->1 held 20 cycles -> one enable pulse 6 cycles after the first sampling edge; busy high from cycle 3.
REQ-029 event_in high for 3 cycles, then low -> no enable, glitch_cnt=1, returns to IDLE.
REQ-030 Debounced high, then a 2-cycle low dip, then high -> no second enable, glitch_cnt+1, state stays ACTIVE.
REQ-031 arm=0 during a clean event -> no enable; busy and the state sequence match the arm=1 run.
REQ-032 300 short glitches -> glitch_cnt=255 and holds there.
REQ-033 Reset asserted 2 cycles into ARMING, then released with event_in still high -> all outputs 0 immediately; enable 6 cycles after the first post-reset sampling edge.
